pet_stat_engine: RTL and testbench

//  Parametrised successor to the fixed 6-stat, 5-bit pet state logic. Holds NUM_STATS

---
 rtl/pet_stat_engine_if.sv | 14 +
 rtl/pet_stat_engine.sv | 143 ++++++++++++++
 tb/tb_pet_stat_engine.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/pet_stat_engine_if.sv
// Command channel between the UART decoder and the pet stat engine.
// Plain valid/ready handshake carrying one stat command per transfer.
interface pet_stat_engine_if #(
   parameter int STAT_W = 5
) ();
   logic              cmd_valid;
   logic              cmd_ready;
   logic [1:0]        cmd_op;
   logic [3:0]        cmd_idx;
   logic [STAT_W-1:0] cmd_amt;

   modport master (output cmd_valid, cmd_op, cmd_idx, cmd_amt, input cmd_ready);
   modport slave  (input cmd_valid, cmd_op, cmd_idx, cmd_amt, output cmd_ready);
endinterface

// File: rtl/pet_stat_engine.sv
// Pet stat engine: NUM_STATS saturating counters with tick-driven decay,
// sleep recovery, command handshake and low/critical/dead flagging.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   S_IDLE  | accept commands; tick moves to S_SWEEP
//   S_SWEEP | one channel decayed/recovered per cycle, k = 0..NUM_STATS-1
//   S_DEAD  | tick stopped, stats frozen, commands swallowed; reset only
module pet_stat_engine #(
   parameter int NUM_STATS  = 6,
   parameter int STAT_W     = 5,
   parameter int TICK_DIV   = 10000000,
   parameter int LOW_THRESH = 4,
   parameter int SLEEP_IDX  = 4,
   parameter int DEAD_TICKS = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [7:0]                    rand_in,
   input  logic                          sleep_req,
   pet_stat_engine_if.slave              cmd,
   output logic                          tick,
   output logic [NUM_STATS*STAT_W-1:0]   stats,
   output logic [NUM_STATS-1:0]          low_mask,
   output logic                          critical,
   output logic                          dead,
   output logic                          cmd_err
);

   localparam int                CNT_W    = $clog2(TICK_DIV);
   localparam int                CRIT_W   = $clog2(DEAD_TICKS + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TICK_DIV - 1);

   typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DEAD} state_t;

   state_t                              state_q, state_d;
   logic [CNT_W-1:0]                    cnt_q;
   logic [3:0]                          k_q;
   logic [7:0]                          j_q;
   logic [CRIT_W-1:0]                   crit_cnt_q, crit_inc;
   logic [NUM_STATS-1:0][STAT_W-1:0]    stat_q, stat_d;
   logic [NUM_STATS-1:0]                low_d;
   logic                                accept, idx_ok, cmd_apply, sweep_last, any_zero;

   function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] a, input logic [STAT_W-1:0] b);
      logic [STAT_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[STAT_W] ? '1 : s[STAT_W-1:0];
   endfunction

   function automatic logic [STAT_W-1:0] sat_sub(input logic [STAT_W-1:0] a, input logic [STAT_W-1:0] b);
      logic [STAT_W:0] d;
      d = {1'b0, a} - {1'b0, b};
      return d[STAT_W] ? '0 : d[STAT_W-1:0];
   endfunction

   assign stats = stat_q;

   // FSM: state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (tick) state_d = S_SWEEP;
         S_SWEEP: if (sweep_last)
                     state_d = (any_zero && crit_inc == CRIT_W'(DEAD_TICKS)) ? S_DEAD : S_IDLE;
         S_DEAD:  state_d = S_DEAD;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM: outputs; a tick in IDLE blocks the handshake so the sweep starts clean
   always_comb begin
      tick          = (cnt_q == CNT_LAST) && (state_q != S_DEAD);
      cmd.cmd_ready = ((state_q == S_IDLE) && !tick) || (state_q == S_DEAD);
      dead          = (state_q == S_DEAD);
   end

   always_comb begin
      accept     = cmd.cmd_valid && cmd.cmd_ready;
      idx_ok     = {1'b0, cmd.cmd_idx} < 5'(NUM_STATS);
      cmd_apply  = accept && (state_q == S_IDLE) && idx_ok;
      sweep_last = (state_q == S_SWEEP) && (k_q == 4'(NUM_STATS - 1));
      crit_inc   = crit_cnt_q + CRIT_W'(1);
      stat_d     = stat_q;
      for (int i = 0; i < NUM_STATS; i++) begin
         if (cmd_apply && cmd.cmd_idx == 4'(i)) begin
            case (cmd.cmd_op)
               2'b01:   stat_d[i] = sat_add(stat_q[i], cmd.cmd_amt);
               2'b10:   stat_d[i] = sat_sub(stat_q[i], cmd.cmd_amt);
               2'b11:   stat_d[i] = cmd.cmd_amt;
               default: stat_d[i] = stat_q[i];
            endcase
         end
         if (state_q == S_SWEEP && k_q == 4'(i)) begin
            if (sleep_req && i == SLEEP_IDX) stat_d[i] = sat_add(stat_q[i], STAT_W'(2));
            else                             stat_d[i] = sat_sub(stat_q[i], STAT_W'(j_q[k_q[2:0]]));
         end
      end
      any_zero = 1'b0;
      low_d    = '0;
      for (int i = 0; i < NUM_STATS; i++) begin
         low_d[i] = (stat_d[i] <= STAT_W'(LOW_THRESH));
         if (stat_d[i] == '0) any_zero = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stat_q     <= '1;
         cnt_q      <= '0;
         k_q        <= '0;
         j_q        <= '0;
         crit_cnt_q <= '0;
         low_mask   <= '0;
         critical   <= 1'b0;
         cmd_err    <= 1'b0;
      end else begin
         stat_q  <= stat_d;
         cmd_err <= accept && (state_q == S_IDLE) && !idx_ok;
         if (state_q != S_DEAD)
            cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
         if (state_q == S_IDLE && tick) begin
            j_q <= rand_in;
            k_q <= '0;
         end else if (state_q == S_SWEEP) begin
            k_q <= k_q + 4'd1;
         end
         if (cmd_apply || sweep_last) begin
            low_mask <= low_d;
            critical <= any_zero;
         end
         if (sweep_last)
            crit_cnt_q <= any_zero ? crit_inc : '0;
      end
   end

endmodule

// File: tb/tb_pet_stat_engine.sv
// Directed bench for pet_stat_engine: command vector table plus hand-written
// tick, sweep, sleep, death and mid-sweep reset sequences.
module tb_pet_stat_engine;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  rand_in = 8'h00;
   logic        sleep_req = 1'b0;
   logic        tick, critical, dead, cmd_err;
   logic [29:0] stats;
   logic [5:0]  low_mask;

   int n_checks = 0;
   int n_fail   = 0;

   pet_stat_engine_if #(.STAT_W(5)) bus ();

   pet_stat_engine #(
      .NUM_STATS(6), .STAT_W(5), .TICK_DIV(16),
      .LOW_THRESH(4), .SLEEP_IDX(4), .DEAD_TICKS(2)
   ) dut (
      .clk(clk), .reset(reset), .rand_in(rand_in), .sleep_req(sleep_req),
      .cmd(bus), .tick(tick), .stats(stats), .low_mask(low_mask),
      .critical(critical), .dead(dead), .cmd_err(cmd_err)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [1:0]  op;
      logic [3:0]  idx;
      logic [4:0]  amt;
      logic [29:0] stats;
      logic        err;
      logic        crit;
      logic [5:0]  low;
   } vec_t;

   vec_t tbl[13];

   function automatic logic [29:0] pk(input int c0, c1, c2, c3, c4, c5);
      return {5'(c5), 5'(c4), 5'(c3), 5'(c2), 5'(c1), 5'(c0)};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_tick();
      int n = 0;
      while (!tick && n < 40) begin step(); n++; end
      check("wait_tick", 32'(tick), 32'd1);
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!bus.cmd_ready && n < 40) begin step(); n++; end
      check("wait_ready", 32'(bus.cmd_ready), 32'd1);
   endtask

   // returns at the first IDLE cycle after the next sweep
   task automatic sync();
      wait_tick();
      step();
      wait_ready();
   endtask

   task automatic apply(input vec_t v, input int id);
      sync();
      bus.cmd_op    = v.op;
      bus.cmd_idx   = v.idx;
      bus.cmd_amt   = v.amt;
      bus.cmd_valid = 1'b1;
      step();
      bus.cmd_valid = 1'b0;
      check($sformatf("vec%0d_stats", id), 32'(stats), 32'(v.stats));
      check($sformatf("vec%0d_err", id), 32'(cmd_err), 32'(v.err));
      check($sformatf("vec%0d_crit", id), 32'(critical), 32'(v.crit));
      check($sformatf("vec%0d_low", id), 32'(low_mask), 32'(v.low));
      step();
      check($sformatf("vec%0d_err_clr", id), 32'(cmd_err), 32'd0);
   endtask

   initial begin
      int n;
      vec_t v;
      //                op     idx    amt     stats ch0..ch5                err   crit  low
      tbl[0]  = '{2'b01, 4'd1, 5'd20, pk(30, 31, 30, 31, 31, 31), 1'b0, 1'b0, 6'b000000};
      tbl[1]  = '{2'b01, 4'd0, 5'd1,  pk(31, 31, 30, 31, 31, 31), 1'b0, 1'b0, 6'b000000};
      tbl[2]  = '{2'b10, 4'd2, 5'd3,  pk(31, 31, 27, 31, 31, 31), 1'b0, 1'b0, 6'b000000};
      tbl[3]  = '{2'b11, 4'd5, 5'd4,  pk(31, 31, 27, 31, 31, 4),  1'b0, 1'b0, 6'b100000};
      tbl[4]  = '{2'b00, 4'd0, 5'd7,  pk(31, 31, 27, 31, 31, 4),  1'b0, 1'b0, 6'b100000};
      tbl[5]  = '{2'b01, 4'd9, 5'd5,  pk(31, 31, 27, 31, 31, 4),  1'b1, 1'b0, 6'b100000};
      tbl[6]  = '{2'b11, 4'd5, 5'd31, pk(31, 31, 27, 31, 31, 31), 1'b0, 1'b0, 6'b000000};
      tbl[7]  = '{2'b10, 4'd2, 5'd30, pk(31, 31, 0,  31, 31, 31), 1'b0, 1'b1, 6'b000100};
      tbl[8]  = '{2'b11, 4'd2, 5'd20, pk(31, 31, 20, 31, 31, 31), 1'b0, 1'b0, 6'b000000};
      tbl[9]  = '{2'b10, 4'd3, 5'd31, pk(31, 31, 20, 0,  31, 31), 1'b0, 1'b1, 6'b001000};
      tbl[10] = '{2'b11, 4'd3, 5'd31, pk(31, 31, 20, 31, 31, 31), 1'b0, 1'b0, 6'b000000};
      tbl[11] = '{2'b01, 4'd2, 5'd15, pk(31, 31, 31, 31, 31, 31), 1'b0, 1'b0, 6'b000000};
      tbl[12] = '{2'b11, 4'd15, 5'd0, pk(31, 31, 31, 31, 31, 31), 1'b1, 1'b0, 6'b000000};

      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 2'b00;
      bus.cmd_idx   = 4'd0;
      bus.cmd_amt   = 5'd0;

      // reset release: this cycle is cycle 0
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      check("rst_stats", 32'(stats), 32'(pk(31, 31, 31, 31, 31, 31)));
      check("rst_tick", 32'(tick), 32'd0);
      check("rst_low", 32'(low_mask), 32'd0);
      check("rst_crit", 32'(critical), 32'd0);
      check("rst_dead", 32'(dead), 32'd0);
      check("rst_err", 32'(cmd_err), 32'd0);
      check("rst_ready", 32'(bus.cmd_ready), 32'd1);
      repeat (14) step();
      check("tick_c14", 32'(tick), 32'd0);
      step();
      check("tick_c15", 32'(tick), 32'd1);
      check("ready_at_tick", 32'(bus.cmd_ready), 32'd0);
      rand_in = 8'h05;
      step();
      check("tick_c16", 32'(tick), 32'd0);
      for (int i = 0; i < 6; i++) begin
         check($sformatf("sweep_ready_k%0d", i), 32'(bus.cmd_ready), 32'd0);
         step();
      end
      rand_in = 8'h00;
      check("sweep_end_ready", 32'(bus.cmd_ready), 32'd1);
      check("sweep1_stats", 32'(stats), 32'(pk(30, 31, 30, 31, 31, 31)));
      check("sweep1_low", 32'(low_mask), 32'd0);

      for (int i = 0; i < 13; i++) apply(tbl[i], i);

      // command presented during the tick waits out the whole sweep
      sync();
      repeat (9) step();
      check("blk_tick", 32'(tick), 32'd1);
      bus.cmd_op = 2'b11; bus.cmd_idx = 4'd0; bus.cmd_amt = 5'd7; bus.cmd_valid = 1'b1;
      n = 0;
      do begin step(); n++; end while (!bus.cmd_ready && n < 20);
      check("blk_wait_cycles", 32'(n), 32'd7);
      check("blk_pending_stats", 32'(stats), 32'(pk(31, 31, 31, 31, 31, 31)));
      step();
      bus.cmd_valid = 1'b0;
      check("blk_applied", 32'(stats), 32'(pk(7, 31, 31, 31, 31, 31)));

      // sleep: energy recovers by 2 while every other channel decays by 1
      v = '{2'b11, 4'd4, 5'd10, pk(7, 31, 31, 31, 10, 31), 1'b0, 1'b0, 6'b000000};
      apply(v, 100);
      sleep_req = 1'b1;
      rand_in   = 8'hFF;
      sync();
      rand_in   = 8'h00;
      check("sleep_sweep", 32'(stats), 32'(pk(6, 30, 30, 30, 12, 30)));
      v = '{2'b11, 4'd4, 5'd31, pk(6, 30, 30, 30, 31, 30), 1'b0, 1'b0, 6'b000000};
      apply(v, 101);
      sync();
      check("sleep_sat", 32'(stats), 32'(pk(6, 30, 30, 30, 31, 30)));
      sleep_req = 1'b0;

      // two consecutive critical sweeps kill the pet
      v = '{2'b10, 4'd3, 5'd31, pk(6, 30, 30, 0, 31, 30), 1'b0, 1'b1, 6'b001000};
      apply(v, 102);
      sync();
      check("crit1_dead", 32'(dead), 32'd0);
      check("crit1_crit", 32'(critical), 32'd1);
      sync();
      check("crit2_dead", 32'(dead), 32'd1);
      check("dead_ready", 32'(bus.cmd_ready), 32'd1);
      check("dead_stats", 32'(stats), 32'(pk(6, 30, 30, 0, 31, 30)));
      n = 0;
      for (int i = 0; i < 40; i++) begin
         if (tick) n++;
         step();
      end
      check("dead_no_tick", 32'(n), 32'd0);
      bus.cmd_op = 2'b11; bus.cmd_idx = 4'd0; bus.cmd_amt = 5'd20; bus.cmd_valid = 1'b1;
      step();
      bus.cmd_valid = 1'b0;
      check("dead_set_ignored", 32'(stats), 32'(pk(6, 30, 30, 0, 31, 30)));
      check("dead_no_err", 32'(cmd_err), 32'd0);
      check("dead_sticky", 32'(dead), 32'd1);

      // reset leaves DEAD; a second reset lands in the middle of a sweep
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("rst2_dead", 32'(dead), 32'd0);
      rand_in = 8'hFF;
      repeat (15) step();
      check("rst2_tick", 32'(tick), 32'd1);
      step();
      rand_in = 8'h00;
      repeat (3) step();
      check("mid_sweep_stats", 32'(stats), 32'(pk(30, 30, 30, 31, 31, 31)));
      reset = 1'b1;
      #1;
      check("abort_stats", 32'(stats), 32'(pk(31, 31, 31, 31, 31, 31)));
      check("abort_dead", 32'(dead), 32'd0);
      check("abort_tick", 32'(tick), 32'd0);
      check("abort_crit", 32'(critical), 32'd0);
      step();
      reset = 1'b0;
      repeat (3) step();
      check("post_abort_stats", 32'(stats), 32'(pk(31, 31, 31, 31, 31, 31)));
      check("post_abort_ready", 32'(bus.cmd_ready), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
